// File: rtl/tt_response_checker_if.sv
// Bus between the response checker and the lab top level / function-under-test.
// The checker drives the stimulus vector and result fields; the lab side drives
// the sweep request and the DUT response.
interface tt_response_checker_if;
  logic        start;
  logic [3:0]  vec_out;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [4:0]  err_count;
  logic        first_err_valid;
  logic [3:0]  first_err_idx;

  // Checker side
  modport master (
    input  start,
    input  dut_y,
    output vec_out,
    output busy,
    output done,
    output pass,
    output captured,
    output err_count,
    output first_err_valid,
    output first_err_idx
  );

  // Lab / stimulus side
  modport slave (
    output start,
    output dut_y,
    input  vec_out,
    input  busy,
    input  done,
    input  pass,
    input  captured,
    input  err_count,
    input  first_err_valid,
    input  first_err_idx
  );
endinterface

// File: rtl/tt_response_checker.sv
// Exhaustive 4-input response checker: walks {A,B,C,D} through all 16 vectors,
// holds each for SETTLE cycles, samples the function-under-test's Y and compares
// it to the GOLDEN truth table. Reports captured responses, mismatch count,
// lowest failing vector and an overall pass flag.
module tt_response_checker #(
  parameter logic [15:0] GOLDEN = 16'hC080,  // bit i = expected Y for vector i
  parameter int unsigned SETTLE = 2          // hold cycles per vector, 1..15
) (
  input logic clk,
  input logic rst,
  tt_response_checker_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);
  localparam logic [3:0] LAST_VEC      = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] cap_q, cap_d;
  logic [4:0]  err_q, err_d;
  logic        fev_q, fev_d;
  logic [3:0]  fei_q, fei_d;

  logic        mismatch;

  assign mismatch = (bus.dut_y != GOLDEN[vec_q]);

  // State and result registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cap_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
    end
  end

  // Next-state: sweep sequencing, response capture and mismatch bookkeeping
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    cap_d   = cap_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_HOLD;
          vec_d   = '0;
          cnt_d   = SETTLE_RELOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cap_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fei_d   = '0;
        end
      end

      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cap_d[vec_q] = bus.dut_y;
          if (mismatch) begin
            err_d = err_q + 5'd1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = vec_q;
            end
          end
          if (vec_q != LAST_VEC) begin
            vec_d = vec_q + 4'd1;
            cnt_d = SETTLE_RELOAD;
          end else begin
            // pass must reflect the final vector's result, so it uses err_d
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.vec_out         = vec_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.captured        = cap_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fei_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: two instances (SETTLE=2 and SETTLE=1) driven by
// table-based functions-under-test; a time-based model predicts every output.
module tb_tt_response_checker;

  localparam logic [15:0] GOLD = 16'hC080;
  localparam int S0 = 2;
  localparam int S1 = 1;

  typedef struct packed {
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] cap;
    logic [4:0]  err;
    logic        fev;
    logic [3:0]  fei;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_r [2];
  logic [15:0] tbl     [2];
  logic [15:0] fut;
  bit          chk_en;
  int          checks;
  int          errors;

  tt_response_checker_if u_if0 ();
  tt_response_checker_if u_if1 ();

  assign u_if0.start = start_r[0];
  assign u_if0.dut_y = tbl[0][u_if0.vec_out];
  assign u_if1.start = start_r[1];
  assign u_if1.dut_y = tbl[1][u_if1.vec_out];

  tt_response_checker #(.GOLDEN(GOLD), .SETTLE(S0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u_if0.master)
  );

  tt_response_checker #(.GOLDEN(GOLD), .SETTLE(S1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.master)
  );

  function automatic int settle_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    if (i == 0)
      o = {u_if0.vec_out, u_if0.busy, u_if0.done, u_if0.pass, u_if0.captured,
           u_if0.err_count, u_if0.first_err_valid, u_if0.first_err_idx};
    else
      o = {u_if1.vec_out, u_if1.busy, u_if1.done, u_if1.pass, u_if1.captured,
           u_if1.err_count, u_if1.first_err_valid, u_if1.first_err_idx};
    return o;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h required=%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Model: a sweep is just "t cycles since the accept edge"; after t cycles
  // floor(t/SETTLE) vectors have been sampled, all of them after 16*SETTLE.
  bit          m_sw  [2];
  bit          m_fin [2];
  int          m_t   [2];
  logic [15:0] m_tbl [2];

  always @(posedge clk) begin : model_upd
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_sw[i]  = 1'b0;
        m_fin[i] = 1'b0;
        m_t[i]   = 0;
      end else if (!m_sw[i] && start_r[i]) begin
        m_sw[i]  = 1'b1;
        m_fin[i] = 1'b0;
        m_t[i]   = 0;
        m_tbl[i] = tbl[i];
      end else if (m_sw[i]) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == 16 * settle_of(i)) begin
          m_sw[i]  = 1'b0;
          m_fin[i] = 1'b1;
        end
      end
    end
  end

  function automatic obs_t exp_of(input int i);
    obs_t        e;
    int          n;
    logic [15:0] mask;
    logic [15:0] miss;
    n    = m_fin[i] ? 16 : (m_sw[i] ? m_t[i] / settle_of(i) : 0);
    mask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
    miss = (m_tbl[i] ^ GOLD) & mask;
    e.vec  = 4'((n > 15) ? 15 : n);
    e.busy = m_sw[i];
    e.done = m_fin[i];
    e.pass = m_fin[i] && (miss == 16'h0);
    e.cap  = m_tbl[i] & mask;
    e.err  = 5'($countones(miss));
    e.fev  = |miss;
    e.fei  = 4'd0;
    for (int b = 15; b >= 0; b--)
      if (miss[b]) e.fei = 4'(b);
    return e;
  endfunction

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin : compare
    obs_t a;
    obs_t e;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        a = get_obs(i);
        e = exp_of(i);
        chk("vec_out",         i, 32'(a.vec),  32'(e.vec));
        chk("busy",            i, 32'(a.busy), 32'(e.busy));
        chk("done",            i, 32'(a.done), 32'(e.done));
        chk("pass",            i, 32'(a.pass), 32'(e.pass));
        chk("captured",        i, 32'(a.cap),  32'(e.cap));
        chk("err_count",       i, 32'(a.err),  32'(e.err));
        chk("first_err_valid", i, 32'(a.fev),  32'(e.fev));
        chk("first_err_idx",   i, 32'(a.fei),  32'(e.fei));
      end
    end
  end

  // Pulse start and count edges from acceptance until done; optional re-pulse mid-sweep
  task automatic run_sweep(input int i, input int repulse_at);
    int   lat;
    obs_t o;
    lat = 0;
    start_r[i] = 1'b1;
    @(posedge clk); #2;
    start_r[i] = 1'b0;
    while (lat < 200) begin
      @(posedge clk); #2;
      lat++;
      start_r[i] = (lat == repulse_at);
      o = get_obs(i);
      if (o.done) break;
    end
    start_r[i] = 1'b0;
    chk("sweep_latency", i, 32'(lat), 32'(16 * settle_of(i)));
  endtask

  task automatic lit_results(input int i, input logic [15:0] cap, input int err,
                             input logic fev, input int fei, input logic pass);
    obs_t o;
    o = get_obs(i);
    chk("lit_done",      i, 32'(o.done), 32'd1);
    chk("lit_captured",  i, 32'(o.cap),  32'(cap));
    chk("lit_err_count", i, 32'(o.err),  32'(err));
    chk("lit_fev",       i, 32'(o.fev),  32'(fev));
    chk("lit_fei",       i, 32'(o.fei),  32'(fei));
    chk("lit_pass",      i, 32'(o.pass), 32'(pass));
  endtask

  task automatic lit_reset(input int i);
    obs_t o;
    o = get_obs(i);
    chk("rst_vec_out",  i, 32'(o.vec),  32'd0);
    chk("rst_busy",     i, 32'(o.busy), 32'd0);
    chk("rst_done",     i, 32'(o.done), 32'd0);
    chk("rst_pass",     i, 32'(o.pass), 32'd0);
    chk("rst_captured", i, 32'(o.cap),  32'd0);
    chk("rst_err",      i, 32'(o.err),  32'd0);
    chk("rst_fev",      i, 32'(o.fev),  32'd0);
    chk("rst_fei",      i, 32'(o.fei),  32'd0);
  endtask

  initial begin : stim
    obs_t o;
    int   guard;
    logic [3:0] v;

    // Function-under-test Y = B & C & (A | D), A = MSB
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      fut[k] = v[2] & v[1] & (v[3] | v[0]);
    end

    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    tbl[0] = fut;
    tbl[1] = fut;
    m_tbl[0] = '0;
    m_tbl[1] = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

    chk("fut_table", 0, 32'(fut), 32'h0000C080);
    lit_reset(0);
    lit_reset(1);

    // Correct function -> pass
    tbl[0] = fut;
    run_sweep(0, -1);
    lit_results(0, 16'hC080, 0, 1'b0, 0, 1'b1);

    // Y stuck at 0
    tbl[0] = 16'h0000;
    run_sweep(0, -1);
    lit_results(0, 16'h0000, 3, 1'b1, 7, 1'b0);

    // Y stuck at 1
    tbl[0] = 16'hFFFF;
    run_sweep(0, -1);
    lit_results(0, 16'hFFFF, 13, 1'b1, 0, 1'b0);

    // Single fault at vector 14
    tbl[0] = fut ^ 16'h4000;
    run_sweep(0, -1);
    lit_results(0, 16'h8080, 1, 1'b1, 14, 1'b0);

    // start re-pulsed mid-sweep must not disturb timing
    tbl[0] = fut;
    run_sweep(0, 10);
    lit_results(0, 16'hC080, 0, 1'b0, 0, 1'b1);

    // start held high in DONE: new sweep begins with results cleared
    start_r[0] = 1'b1;
    @(posedge clk); #2;
    o = get_obs(0);
    chk("held_start_busy", 0, 32'(o.busy), 32'd1);
    chk("held_start_done", 0, 32'(o.done), 32'd0);
    chk("held_start_cap",  0, 32'(o.cap),  32'd0);
    repeat (40) begin
      @(posedge clk); #2;
    end
    start_r[0] = 1'b0;
    guard = 0;
    do begin
      @(posedge clk); #2;
      guard++;
      o = get_obs(0);
    end while (!o.done && guard < 100);
    chk("held_start_finish", 0, 32'(o.done), 32'd1);

    // rst mid-sweep at vec_out = 5
    tbl[0] = 16'hFFFF;
    start_r[0] = 1'b1;
    @(posedge clk); #2;
    start_r[0] = 1'b0;
    guard = 0;
    do begin
      @(posedge clk); #2;
      guard++;
      o = get_obs(0);
    end while (o.vec != 4'd5 && guard < 100);
    chk("reach_vec5", 0, 32'(o.vec), 32'd5);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    lit_reset(0);
    tbl[0] = fut;
    run_sweep(0, -1);
    lit_results(0, 16'hC080, 0, 1'b0, 0, 1'b1);

    // SETTLE = 1 instance: 16-cycle sweep
    tbl[1] = fut;
    run_sweep(1, -1);
    lit_results(1, 16'hC080, 0, 1'b0, 0, 1'b1);
    tbl[1] = fut ^ 16'h0101;
    run_sweep(1, -1);
    lit_results(1, 16'hC181, 2, 1'b1, 0, 1'b0);

    // Randomized traffic: random functions, start pulses and occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_sw[i] && $urandom_range(2) == 0) begin
          case ($urandom_range(3))
            0: tbl[i] = fut;
            1: tbl[i] = 16'h0000;
            2: tbl[i] = 16'hFFFF;
            default: tbl[i] = 16'($urandom);
          endcase
        end
        start_r[i] = ($urandom_range(4) == 0);
      end
      rst = ($urandom_range(249) == 0);
      @(posedge clk); #2;
    end
    rst = 1'b0;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    @(posedge clk); #2;

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
